// File: rtl/riscv_mdu.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide, BITS_PER_CYCLE bits per cycle.
// Latency: N_CALC+1 cycles from start to done; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: none; start is ignored while busy or done, flush aborts to IDLE. Optional: RISCV_MDU_FAST_MUL_EN (1-cycle multiplies).
module riscv_mdu #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_mdu_start,
   input  logic [2:0]      i_mdu_funct3,
   input  logic [XLEN-1:0] i_mdu_a,
   input  logic [XLEN-1:0] i_mdu_b,
   input  logic            i_mdu_flush,
   output logic            o_mdu_busy,
   output logic            o_mdu_done,
   output logic [XLEN-1:0] o_mdu_result
);

   localparam int N_CALC = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W  = $clog2(N_CALC + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // acc holds {partial product, multiplier} for multiplies, {remainder, dividend/quotient} for divides
   logic [2*XLEN-1:0]   acc_q, acc_d;
   // mag holds |a| (multiplicand) for multiplies, |b| (divisor) for divides
   logic [XLEN-1:0]     mag_q, mag_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;

   // operand decode at entry
   logic                a_sen_w, b_sen_w, a_neg_w, b_neg_w, ovf_w, dz_w, is_div_w;
   logic [XLEN-1:0]     a_mag_w, b_mag_w;

   assign is_div_w = i_mdu_funct3[2];
   // a is signed for MUL/MULH/MULHSU/DIV/REM; b additionally unsigned for MULHSU
   assign a_sen_w  = ~(i_mdu_funct3[0] & (i_mdu_funct3[1] | i_mdu_funct3[2]));
   assign b_sen_w  = a_sen_w & (i_mdu_funct3 != 3'b010);
   assign a_neg_w  = a_sen_w & i_mdu_a[XLEN-1];
   assign b_neg_w  = b_sen_w & i_mdu_b[XLEN-1];
   assign a_mag_w  = a_neg_w ? -i_mdu_a : i_mdu_a;
   assign b_mag_w  = b_neg_w ? -i_mdu_b : i_mdu_b;
   assign dz_w     = is_div_w & (i_mdu_b == '0);
   assign ovf_w    = is_div_w & ~i_mdu_funct3[0] & (i_mdu_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_mdu_b);

   // one CALC cycle worth of shift-add or restoring-divide steps
   logic [2*XLEN-1:0]   step_w;
   logic [XLEN:0]       shf_w, sum_w;

   always_comb begin
      step_w = acc_q;
      shf_w  = '0;
      sum_w  = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (f3_q[2]) begin
            shf_w = {step_w[2*XLEN-1:XLEN], step_w[XLEN-1]};
            if (shf_w >= {1'b0, mag_q}) begin
               sum_w  = shf_w - {1'b0, mag_q};
               step_w = {sum_w[XLEN-1:0], step_w[XLEN-2:0], 1'b1};
            end else begin
               step_w = {shf_w[XLEN-1:0], step_w[XLEN-2:0], 1'b0};
            end
         end else begin
            sum_w  = {1'b0, step_w[2*XLEN-1:XLEN]} + (step_w[0] ? {1'b0, mag_q} : '0);
            step_w = {sum_w, step_w[XLEN-1:1]};
         end
      end
   end

   // sign correction of the final step, applied on the edge into DONE
   logic [2*XLEN-1:0]   fix_p_w;
   logic [XLEN-1:0]     fix_q_w, fix_r_w, calc_res_w;

   assign fix_p_w    = neg_q ? -step_w : step_w;
   assign fix_q_w    = neg_q ? -step_w[XLEN-1:0] : step_w[XLEN-1:0];
   assign fix_r_w    = neg_q ? -step_w[2*XLEN-1:XLEN] : step_w[2*XLEN-1:XLEN];
   assign calc_res_w = f3_q[2] ? (f3_q[1] ? fix_r_w : fix_q_w)
                               : ((f3_q[1:0] == 2'b00) ? fix_p_w[XLEN-1:0] : fix_p_w[2*XLEN-1:XLEN]);

`ifdef RISCV_MDU_FAST_MUL_EN
   // single-cycle product; the low 2*XLEN bits of the sign-extended product are exact
   logic signed [XLEN:0]     fa_w, fb_w;
   logic signed [2*XLEN-1:0] fp_w;
   logic [XLEN-1:0]          fast_res_w;

   assign fa_w       = {a_sen_w & i_mdu_a[XLEN-1], i_mdu_a};
   assign fb_w       = {b_sen_w & i_mdu_b[XLEN-1], i_mdu_b};
   assign fp_w       = (2*XLEN)'(fa_w) * (2*XLEN)'(fb_w);
   assign fast_res_w = (i_mdu_funct3[1:0] == 2'b00) ? fp_w[XLEN-1:0] : fp_w[2*XLEN-1:XLEN];
`endif

   // next-state and datapath control; flush overrides everything
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mag_d    = mag_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (i_mdu_start) begin
               f3_d  = i_mdu_funct3;
               neg_d = (i_mdu_funct3 == 3'b110) ? a_neg_w : (a_neg_w ^ b_neg_w);
               mag_d = is_div_w ? b_mag_w : a_mag_w;
               acc_d = {{XLEN{1'b0}}, (is_div_w ? a_mag_w : b_mag_w)};
               cnt_d = '0;
               if (dz_w) begin
                  result_d = i_mdu_funct3[1] ? i_mdu_a : '1;
                  state_d  = DONE;
               end else if (ovf_w) begin
                  result_d = i_mdu_funct3[1] ? '0 : i_mdu_a;
                  state_d  = DONE;
               end
`ifdef RISCV_MDU_FAST_MUL_EN
               else if (!is_div_w) begin
                  result_d = fast_res_w;
                  state_d  = DONE;
               end
`endif
               else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step_w;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N_CALC - 1)) begin
               result_d = calc_res_w;
               state_d  = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (i_mdu_flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // state and datapath registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mag_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mag_q    <= mag_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign o_mdu_busy   = (state_q == CALC);
   assign o_mdu_done   = (state_q == DONE);
   assign o_mdu_result = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Bench for riscv_mdu: directed vector table, model-checked random ops, flush/reset/start-ignore sequences.
// Latency: checks exact done cycle per op; a second instance covers BITS_PER_CYCLE=4.
// Backpressure: n/a; every wait is bounded.
module tb_riscv_mdu;

   localparam int DIV_LAT  = 33;
   localparam int DIV_LAT4 = 9;
`ifdef RISCV_MDU_FAST_MUL_EN
   localparam int MUL_LAT  = 1;
   localparam int MUL_LAT4 = 1;
`else
   localparam int MUL_LAT  = 33;
   localparam int MUL_LAT4 = 9;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        start, flush;
   logic [2:0]  f3;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   logic        start4, flush4;
   logic [2:0]  f3_4;
   logic [31:0] a4, b4;
   logic        busy4, done4;
   logic [31:0] result4;

   always #5 clk = ~clk;

   riscv_mdu dut (
      .i_clk(clk), .i_rstn(rstn), .i_mdu_start(start), .i_mdu_funct3(f3),
      .i_mdu_a(a), .i_mdu_b(b), .i_mdu_flush(flush),
      .o_mdu_busy(busy), .o_mdu_done(done), .o_mdu_result(result)
   );

   riscv_mdu #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
      .i_clk(clk), .i_rstn(rstn), .i_mdu_start(start4), .i_mdu_funct3(f3_4),
      .i_mdu_a(a4), .i_mdu_b(b4), .i_mdu_flush(flush4),
      .o_mdu_busy(busy4), .o_mdu_done(done4), .o_mdu_result(result4)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];
   int          lat_q[$];
   logic [31:0] last_exp = '0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[20];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // reference results straight from the RV32M definitions
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      logic [63:0]        p;
      logic               ovf;
      sx  = {{32{x[31]}}, x};
      sy  = {{32{y[31]}}, y};
      ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
      p   = '0;
      case (op)
         3'd0: begin p = sx * sy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * $signed({32'd0, y}); return p[63:32]; end
         3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
         3'd4: if (y == 0) return 32'hFFFFFFFF; else if (ovf) return x; else return 32'($signed(x) / $signed(y));
         3'd5: if (y == 0) return 32'hFFFFFFFF; else return x / y;
         3'd6: if (y == 0) return x; else if (ovf) return 32'd0; else return 32'($signed(x) % $signed(y));
         default: if (y == 0) return x; else return x % y;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      if (op[2] && (y == 0 || (!op[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
      return op[2] ? DIV_LAT : MUL_LAT;
   endfunction

   // drive one op on the default instance; expectations queued at issue, compared at done
   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] want, input int lat);
      int n, busy_n;
      logic [31:0] ew;
      int          el;
      exp_q.push_back(want);
      lat_q.push_back(lat);
      @(posedge clk); #1;
      start = 1'b1; f3 = op; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1; busy_n = 0;
      while (!done && n < lat + 4) begin
         if (busy) busy_n++;
         @(posedge clk); #1;
         n++;
      end
      ew = exp_q.pop_front();
      el = lat_q.pop_front();
      check({nm, " done"}, 32'(done), 32'd1);
      check({nm, " latency"}, 32'(n), 32'(el));
      check({nm, " busy cycles"}, 32'(busy_n), 32'(el - 1));
      check({nm, " result"}, result, ew);
      last_exp = ew;
      @(posedge clk); #1;
      check({nm, " done pulse"}, 32'(done), 32'd0);
      check({nm, " hold"}, result, ew);
   endtask

   task automatic run4(input string nm, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] want, input int lat);
      int n;
      @(posedge clk); #1;
      start4 = 1'b1; f3_4 = op; a4 = x; b4 = y;
      @(posedge clk); #1;
      start4 = 1'b0;
      n = 1;
      while (!done4 && n < lat + 4) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, " done"}, 32'(done4), 32'd1);
      check({nm, " latency"}, 32'(n), 32'(lat));
      check({nm, " result"}, result4, want);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ndone, ndone_at;
      logic [31:0] ra, rb, rres;
      logic [2:0]  rop;

      vt[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
      vt[1]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT};
      vt[2]  = '{3'd3, 32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT};
      vt[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
      vt[4]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
      vt[5]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, MUL_LAT};
      vt[6]  = '{3'd4, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFA, DIV_LAT};
      vt[7]  = '{3'd6, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, DIV_LAT};
      vt[8]  = '{3'd5, 32'd100,        32'd7,        32'd14,       DIV_LAT};
      vt[9]  = '{3'd7, 32'd100,        32'd7,        32'd2,        DIV_LAT};
      vt[10] = '{3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
      vt[11] = '{3'd6, 32'd7,          32'hFFFFFFFE, 32'd1,        DIV_LAT};
      vt[12] = '{3'd5, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, DIV_LAT};
      vt[13] = '{3'd7, 32'hFFFFFFFF,   32'd1,        32'd0,        DIV_LAT};
      vt[14] = '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
      vt[15] = '{3'd7, 32'd5,          32'd0,        32'd5,        1};
      vt[16] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
      vt[17] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
      vt[18] = '{3'd5, 32'd123,        32'd0,        32'hFFFFFFFF, 1};
      vt[19] = '{3'd6, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1};

      rstn = 1'b0; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
      start4 = 1'b0; flush4 = 1'b0; f3_4 = '0; a4 = '0; b4 = '0;
      #12;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      check("reset busy4", 32'(busy4), 32'd0);
      check("reset result4", result4, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < 20; i++)
         run_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (i % 4 == 1) rb = 32'($urandom_range(1, 9));
         run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
      end

      // flush in CALC cycle 10 of a DIVU
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'd5; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      repeat (9) begin @(posedge clk); #1; n++; end
      check("flush pre busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      check("flush result", result, last_exp);
      ndone = 0;
      repeat (3) begin @(posedge clk); #1; if (done) ndone++; end
      check("flush no done", 32'(ndone), 32'd0);
      run_op("after flush", 3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT);

      // a start pulsed mid-CALC must be ignored
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'd5; a = 32'd1000; b = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1; ndone = 0; ndone_at = 0; rres = '0;
      while (n < 50) begin
         if (n == 5) begin start = 1'b1; f3 = 3'd5; a = 32'd9; b = 32'd3; end
         else start = 1'b0;
         if (done) begin ndone++; ndone_at = n; rres = result; end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("ignore start dones", 32'(ndone), 32'd1);
      check("ignore start latency", 32'(ndone_at), 32'(DIV_LAT));
      check("ignore start result", rres, 32'd100);

      // asynchronous reset mid-CALC
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'd5; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("arst busy", 32'(busy), 32'd0);
      check("arst done", 32'(done), 32'd0);
      check("arst result", result, 32'd0);
      #2;
      rstn = 1'b1;
      last_exp = '0;
      run_op("after arst", 3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT);

      // four bits per cycle instance
      run4("bpc4 divu", 3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT4);
      run4("bpc4 mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT4);
      run4("bpc4 rem", 3'd6, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, DIV_LAT4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
